// File: rtl/uart_tx_pkg.sv
// Shared constants and state encoding for the UART transmit framing path.
package uart_tx_pkg;

    localparam int DATA_WIDTH = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } tx_state_e;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity generator: XOR-reduce of the data word, inverted for odd parity.
module uart_parity_calc
    import uart_tx_pkg::*;
#(
    parameter int Data_Width = DATA_WIDTH
) (
    input  logic [Data_Width-1:0] data_i,
    input  logic                  par_typ_i,
    output logic                  par_bit_o
);

    assign par_bit_o = (par_typ_i == PAR_ODD) ? ~(^data_i) : (^data_i);

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART TX framing controller: accepts a byte, loads the serializer and builds
// start / data / optional parity / stop on a registered, idle-high line.
module uart_tx_frame_ctrl
    import uart_tx_pkg::*;
#(
    parameter int Data_Width = DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [Data_Width-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  Ser_Data,
    input  logic                  Ser_Done,
    output logic                  Ser_Enable,
    output logic [Data_Width-1:0] Ser_PData,
    output logic                  TX_OUT,
    output logic                  Busy
);

    tx_state_e             state_q, state_d;
    logic [Data_Width-1:0] pdata_q, pdata_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  tx_out_q;
    logic                  busy_q;
    logic                  par_bit_calc;
    logic                  line_val;
    logic                  ser_en;
    logic                  accept;

    uart_parity_calc #(
        .Data_Width (Data_Width)
    ) u_parity (
        .data_i    (P_DATA),
        .par_typ_i (PAR_TYP),
        .par_bit_o (par_bit_calc)
    );

    // Busy still high in the first IDLE cycle after STOP enforces the idle gap.
    assign accept = (state_q == IDLE) && !busy_q && Data_Valid;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d   = state_q;
        pdata_d   = pdata_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        line_val  = 1'b1;
        ser_en    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    pdata_d   = P_DATA;
                    par_en_d  = PAR_EN;
                    par_bit_d = par_bit_calc;
                    state_d   = START;
                end
            end
            START: begin
                line_val = 1'b0;
                ser_en   = 1'b1;
                state_d  = DATA;
            end
            DATA: begin
                // Frame length is owned by the serializer's Done flag.
                line_val = Ser_Data;
                if (Ser_Done) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                line_val = par_bit_q;
                state_d  = STOP;
            end
            STOP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!RST) begin
            state_q   <= IDLE;
            pdata_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_out_q  <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pdata_q   <= pdata_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_out_q  <= line_val;
            busy_q    <= (state_q != IDLE);
        end
    end

    assign Ser_Enable = ser_en;
    assign Ser_PData  = pdata_q;
    assign TX_OUT     = tx_out_q;
    assign Busy       = busy_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Scoreboard bench for uart_tx_frame_ctrl with a behavioural serializer attached.
module tb_uart_tx_frame_ctrl;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       Ser_Data;
    logic       Ser_Done;
    logic       Ser_Enable;
    logic [7:0] Ser_PData;
    logic       TX_OUT;
    logic       Busy;

    uart_tx_frame_ctrl #(.Data_Width(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Ser_Data   (Ser_Data),
        .Ser_Done   (Ser_Done),
        .Ser_Enable (Ser_Enable),
        .Ser_PData  (Ser_PData),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Serializer: loads on Ser_Enable, shows bit0 next cycle, Done with bit7, then holds.
    logic [7:0] ser_sh;
    logic [2:0] ser_cnt;
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ser_sh  <= 8'h00;
            ser_cnt <= 3'd0;
        end else if (Ser_Enable) begin
            ser_sh  <= Ser_PData;
            ser_cnt <= 3'd0;
        end else if (ser_cnt != 3'd7) begin
            ser_sh  <= ser_sh >> 1;
            ser_cnt <= ser_cnt + 3'd1;
        end
    end
    assign Ser_Data = ser_sh[0];
    assign Ser_Done = (ser_cnt == 3'd7);

    int cyc_cnt = 0;
    always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        logic       val;
        int         cyc;
        logic [7:0] dbyte;
    } line_bit_t;

    line_bit_t line_q[$];
    int        en_q[$];
    int        next_free = 0;
    int        n_checks  = 0;
    int        n_errors  = 0;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc_cnt, act, exp);
        end
    endtask

    // Reference frame: start 0, data LSB-first, optional parity, stop 1; one bit per cycle from acc+2.
    task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt, input int acc);
        int   t;
        logic pbit;
        pbit = logic'($countones(d) % 2) ^ pt;
        t = acc + 2;
        line_q.push_back('{1'b0, t, d});
        for (int i = 0; i < 8; i++) begin
            t++;
            line_q.push_back('{d[i], t, d});
        end
        if (pe) begin
            t++;
            line_q.push_back('{pbit, t, d});
        end
        t++;
        line_q.push_back('{1'b1, t, d});
        en_q.push_back(acc + 1);
        next_free = acc + (pe ? 13 : 12);
    endtask

    task automatic tick(input logic v, input logic [7:0] d, input logic pe, input logic pt);
        @(posedge CLK);
        #1;
        Data_Valid = v;
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        if (v && RST && cyc_cnt >= next_free) push_frame(d, pe, pt, cyc_cnt);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic reset_now(input int hold);
        @(posedge CLK);
        #1;
        RST        = 1'b0;
        Data_Valid = 1'b0;
        line_q.delete();
        en_q.delete();
        #1;
        check(TX_OUT == 1'b1, "rst_tx_out", int'(TX_OUT), 1);
        check(Busy == 1'b0, "rst_busy", int'(Busy), 0);
        check(Ser_Enable == 1'b0, "rst_ser_en", int'(Ser_Enable), 0);
        check(Ser_PData == 8'h00, "rst_pdata", int'(Ser_PData), 0);
        repeat (hold) @(posedge CLK);
        #1;
        RST       = 1'b1;
        next_free = 0;
    endtask

    // Monitor: compares line bits, Ser_PData and load pulses against the scoreboard.
    always @(negedge CLK) begin
        if (RST) begin
            if (Busy) begin
                if (line_q.size() == 0) begin
                    check(1'b0, "busy_unexpected", int'(Busy), 0);
                end else begin
                    line_bit_t e;
                    e = line_q.pop_front();
                    check(TX_OUT == e.val, "tx_bit", int'(TX_OUT), int'(e.val));
                    check(cyc_cnt == e.cyc, "tx_bit_cycle", cyc_cnt, e.cyc);
                    check(Ser_PData == e.dbyte, "ser_pdata", int'(Ser_PData), int'(e.dbyte));
                end
            end else begin
                check(TX_OUT == 1'b1, "idle_high", int'(TX_OUT), 1);
                if (line_q.size() != 0 && line_q[0].cyc <= cyc_cnt)
                    check(1'b0, "busy_missing", int'(Busy), 1);
            end
            if (Ser_Enable) begin
                if (en_q.size() == 0) begin
                    check(1'b0, "ser_en_unexpected", int'(Ser_Enable), 0);
                end else begin
                    int ec;
                    ec = en_q.pop_front();
                    check(cyc_cnt == ec, "ser_en_cycle", cyc_cnt, ec);
                end
            end else if (en_q.size() != 0 && en_q[0] <= cyc_cnt) begin
                check(1'b0, "ser_en_missing", int'(Ser_Enable), 1);
                void'(en_q.pop_front());
            end
        end
    end

    initial begin
        RST        = 1'b0;
        Data_Valid = 1'b0;
        P_DATA     = 8'h00;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check(TX_OUT == 1'b1, "reset_tx_out", int'(TX_OUT), 1);
        check(Busy == 1'b0, "reset_busy", int'(Busy), 0);
        check(Ser_Enable == 1'b0, "reset_ser_en", int'(Ser_Enable), 0);
        check(Ser_PData == 8'h00, "reset_pdata", int'(Ser_PData), 0);
        RST = 1'b1;
        idle(20);

        // Directed frames.
        tick(1'b1, 8'hA5, 1'b0, 1'b0); idle(12);
        tick(1'b1, 8'hA5, 1'b1, 1'b0); idle(13);
        tick(1'b1, 8'hA5, 1'b1, 1'b1); idle(13);
        tick(1'b1, 8'h01, 1'b1, 1'b1); idle(13);

        // Requests at cycles 5 and 12 of a parity frame are dropped; 13 is taken.
        tick(1'b1, 8'h96, 1'b1, 1'b0); idle(4);
        tick(1'b1, 8'hFF, 1'b0, 1'b1); idle(6);
        tick(1'b1, 8'h0F, 1'b0, 1'b0);
        tick(1'b1, 8'hC3, 1'b0, 1'b1); idle(14);

        // Reset at cycle 6 of a frame, then a clean frame.
        tick(1'b1, 8'h5A, 1'b1, 1'b0); idle(5);
        reset_now(2);
        idle(3);
        tick(1'b1, 8'h3C, 1'b1, 1'b1); idle(14);

        // Random traffic with frequent requests, many of them arriving while busy.
        for (int i = 0; i < 800; i++) begin
            tick(1'($urandom_range(4, 0) == 0), 8'($urandom), 1'($urandom), 1'($urandom));
        end
        idle(20);

        check(line_q.size() == 0, "line_q_drained", line_q.size(), 0);
        check(en_q.size() == 0, "en_q_drained", en_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
